pwm_gen_servo_multi: RTL and testbench

Parametrised N-channel servo PWM generator, the successor of the fixed 6-channel servo PWM block. Sits between the command register file and the servo output pins. It produces one shared-period PWM frame per channel, with 1 LSB = 1 pwm_tick. New widths are applied atomically at the frame boundary, clamped to a programmable safe range, and optionally replaced by failsafe widths when commands stop arriving.

---
 rtl/pwm_servo_pkg.sv | 14 +
 rtl/pwm_gen_servo_multi_if.sv | 37 +++
 rtl/pwm_servo_channel.sv | 54 +++++
 rtl/pwm_gen_servo_multi.sv | 143 ++++++++++++++
 tb/tb_pwm_gen_servo_multi.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_servo_pkg.sv
// pwm_servo_pkg: shared defaults for the multi-channel servo PWM generator.
//   DefWidth           - default bit width of period and pulse-width words
//   DefPeriod          - standard servo frame length in ticks (20 ms at 1 MHz)
//   DefWidthMin/Max    - default safe clamp range in ticks
//   DefFailsafePeriods - default frames without commands before failsafe engages
package pwm_servo_pkg;

    localparam int unsigned DefWidth           = 15;
    localparam int unsigned DefPeriod          = 20000;
    localparam int unsigned DefWidthMin        = 900;
    localparam int unsigned DefWidthMax        = 2100;
    localparam int unsigned DefFailsafePeriods = 50;

endpackage

// File: rtl/pwm_gen_servo_multi_if.sv
// pwm_gen_servo_multi_if: command/output bundle of the servo PWM generator.
//   master modport (command side): drives tick, period, widths, clamp bounds,
//     failsafe widths and the data_update strobe; observes the outputs.
//   slave modport (generator): the reverse.
//   pulse_width / failsafe_width: channel k at [k*WIDTH +: WIDTH].
interface pwm_gen_servo_multi_if
    import pwm_servo_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned WIDTH  = DefWidth
);

    logic                    pwm_tick;
    logic [WIDTH-1:0]        pulse_period;
    logic [NUM_CH*WIDTH-1:0] pulse_width;
    logic [WIDTH-1:0]        width_min;
    logic [WIDTH-1:0]        width_max;
    logic [NUM_CH*WIDTH-1:0] failsafe_width;
    logic                    data_update;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    frame_start;
    logic                    update_applied;
    logic                    failsafe_active;

    modport master (
        output pwm_tick, pulse_period, pulse_width, width_min, width_max,
               failsafe_width, data_update,
        input  pwm_out, frame_start, update_applied, failsafe_active
    );

    modport slave (
        input  pwm_tick, pulse_period, pulse_width, width_min, width_max,
               failsafe_width, data_update,
        output pwm_out, frame_start, update_applied, failsafe_active
    );

endinterface

// File: rtl/pwm_servo_channel.sv
// pwm_servo_channel: one PWM output channel.
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture the clamped width_in into the shadow register
//   width_in   - raw width (normal or failsafe, selected by the top level)
//   width_min  - lower clamp bound
//   width_max  - upper clamp bound (wins when the bounds are inverted)
//   cnt        - shared frame counter (1..period)
//   enable     - low forces the output low (degenerate period)
//   pwm        - registered PWM output
module pwm_servo_channel
    import pwm_servo_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] width_in,
    input  logic [WIDTH-1:0] width_min,
    input  logic [WIDTH-1:0] width_max,
    input  logic [WIDTH-1:0] cnt,
    input  logic             enable,
    output logic             pwm
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] capped;
    logic [WIDTH-1:0] clamped;

    always_comb begin
        capped  = (width_in > width_max) ? width_max : width_in;
        clamped = capped;
        if (width_min > width_max) begin
            clamped = width_max;
        end else if (capped < width_min) begin
            clamped = width_min;
        end
    end

    // Shadow and counter both update on the load edge, so the compare sees
    // the new width starting with cnt=1 of the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            pwm      <= 1'b0;
        end else begin
            if (load) begin
                shadow_q <= clamped;
            end
            pwm <= enable && (shadow_q != '0) && (cnt <= shadow_q);
        end
    end

endmodule

// File: rtl/pwm_gen_servo_multi.sv
// pwm_gen_servo_multi: N-channel servo PWM generator with a shared frame.
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - pwm_gen_servo_multi_if.slave (tick, period, widths, clamp bounds,
//          failsafe widths, data_update in; pwm_out, frame_start,
//          update_applied, failsafe_active out)
// Optional feature macro: PWM_SERVO_FAILSAFE_EN builds the frame watchdog that
// swaps in failsafe_width when commands stop. FAILSAFE_PERIODS must be >= 1.
module pwm_gen_servo_multi
    import pwm_servo_pkg::*;
#(
    parameter int unsigned NUM_CH           = 8,
    parameter int unsigned WIDTH            = DefWidth,
    parameter int unsigned FAILSAFE_PERIODS = DefFailsafePeriods
) (
    input logic                  clk,
    input logic                  rst,
    pwm_gen_servo_multi_if.slave bus
);

    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              frame_start_q;
    logic              update_applied_q;
    logic              period_ok;
    logic              boundary;
    logic              load_norm;
    logic              load_fs;
    logic              load_any;
    logic [NUM_CH-1:0] pwm;

    // Period 0 or 1: counter parks at 1, no frames, outputs forced low.
    assign period_ok = bus.pulse_period > WIDTH'(1);
    // >= rather than == so a period lowered below cnt wraps on the next tick.
    assign boundary  = bus.pwm_tick && (cnt_q >= bus.pulse_period);
    // An update on the boundary tick itself loads immediately.
    assign load_norm = boundary && (pending_q || bus.data_update);
    assign load_any  = load_norm || load_fs;

    always_comb begin
        cnt_d = cnt_q;
        if (boundary) begin
            cnt_d = WIDTH'(1);
        end else if (bus.pwm_tick) begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        pending_d = pending_q;
        if (load_norm) begin
            pending_d = 1'b0;
        end else if (bus.data_update) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q            <= WIDTH'(1);
            pending_q        <= 1'b0;
            frame_start_q    <= 1'b0;
            update_applied_q <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            pending_q        <= pending_d;
            frame_start_q    <= boundary && period_ok;
            update_applied_q <= load_norm;
        end
    end

    assign bus.frame_start    = frame_start_q;
    assign bus.update_applied = update_applied_q;

`ifdef PWM_SERVO_FAILSAFE_EN
    localparam int unsigned WdW = $clog2(FAILSAFE_PERIODS + 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           fs_active_q, fs_active_d;
    logic           wd_hit;

    // Saturates at FAILSAFE_PERIODS; while saturated every boundary without a
    // pending command reloads the failsafe widths.
    assign wd_hit  = wd_q >= WdW'(FAILSAFE_PERIODS);
    assign load_fs = boundary && !load_norm && wd_hit;

    always_comb begin
        wd_d = wd_q;
        if (bus.data_update) begin
            wd_d = '0;
        end else if (boundary && period_ok && !wd_hit) begin
            wd_d = wd_q + WdW'(1);
        end

        fs_active_d = fs_active_q;
        if (load_norm) begin
            fs_active_d = 1'b0;
        end else if (load_fs) begin
            fs_active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q        <= '0;
            fs_active_q <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            fs_active_q <= fs_active_d;
        end
    end

    assign bus.failsafe_active = fs_active_q;
`else
    logic unused_failsafe;

    assign load_fs             = 1'b0;
    assign bus.failsafe_active = 1'b0;
    assign unused_failsafe     = ^{bus.failsafe_width, (FAILSAFE_PERIODS != 0)};
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [WIDTH-1:0] width_sel;

        assign width_sel = load_fs ? bus.failsafe_width[k*WIDTH +: WIDTH]
                                   : bus.pulse_width[k*WIDTH +: WIDTH];

        pwm_servo_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .load     (load_any),
            .width_in (width_sel),
            .width_min(bus.width_min),
            .width_max(bus.width_max),
            .cnt      (cnt_q),
            .enable   (period_ok),
            .pwm      (pwm[k])
        );
    end

    assign bus.pwm_out = pwm;

endmodule

// File: tb/tb_pwm_gen_servo_multi.sv
// tb_pwm_gen_servo_multi: self-checking bench for pwm_gen_servo_multi.
// Expected per-frame high times are pushed to a queue when an update is
// driven and popped when the DUT plays the corresponding frame.
`timescale 1ns/1ps
module tb_pwm_gen_servo_multi;
    import pwm_servo_pkg::*;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 15;
    localparam int unsigned FP     = 3;

    typedef logic [NUM_CH*WIDTH-1:0] exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   meas_hi[NUM_CH];
    int   ua_seen;

    always #5 clk = ~clk;

    pwm_gen_servo_multi_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

    pwm_gen_servo_multi #(
        .NUM_CH(NUM_CH),
        .WIDTH(WIDTH),
        .FAILSAFE_PERIODS(FP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic wait_fs(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ua(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.update_applied) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Call on the frame_start negedge; returns on the next frame_start negedge.
    task automatic measure_frame();
        int per;
        per = int'(bus.pulse_period);
        for (int k = 0; k < NUM_CH; k++) meas_hi[k] = 0;
        ua_seen = 0;
        for (int i = 1; i <= per; i++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) if (bus.pwm_out[k]) meas_hi[k]++;
            if (bus.update_applied) ua_seen++;
        end
    endtask

    task automatic send_update(input exp_t raw);
        bus.pulse_width = raw;
        bus.data_update = 1'b1;
        @(negedge clk);
        bus.data_update = 1'b0;
    endtask

    task automatic test_reset();
        int hi, fs;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.pwm_out !== '0) begin
            failures++; $display("FAIL reset_pwm got=%b exp=0", bus.pwm_out);
        end
        checks++;
        if (bus.frame_start !== 1'b0) begin
            failures++; $display("FAIL reset_frame_start got=%b exp=0", bus.frame_start);
        end
        checks++;
        if (bus.update_applied !== 1'b0) begin
            failures++; $display("FAIL reset_update_applied got=%b exp=0", bus.update_applied);
        end
        checks++;
        if (bus.failsafe_active !== 1'b0) begin
            failures++; $display("FAIL reset_failsafe got=%b exp=0", bus.failsafe_active);
        end
        rst = 1'b0;
        bus.pwm_tick = 1'b1;
        hi = 0; fs = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.pwm_out != '0) hi++;
            if (bus.frame_start) fs++;
        end
        checks++;
        if (hi != 0) begin
            failures++; $display("FAIL post_reset_low got=%0d high cycles exp=0", hi);
        end
        checks++;
        if (fs != 2) begin
            failures++; $display("FAIL post_reset_frames got=%0d exp=2", fs);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        bit   ok;
        bus.width_min = '0;
        bus.width_max = 15'd30;
        exp_q.push_back({15'd20, 15'd19, 15'd5, 15'd0});
        send_update({15'd25, 15'd19, 15'd5, 15'd0});
        wait_ua(100, ok);
        checks++;
        if (!ok || !bus.frame_start) begin
            failures++; $display("FAIL basic_load got=%0b exp=1", ok && bus.frame_start);
        end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL basic_high ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
        checks++;
        if (ua_seen != 0) begin
            failures++; $display("FAIL basic_single_load got=%0d extra exp=0", ua_seen);
        end
    endtask

    task automatic test_mid_frame();
        exp_t e;
        bit   ok;
        int   hi[NUM_CH];
        wait_fs(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_wait_frame got=timeout exp=frame"); end
        for (int k = 0; k < NUM_CH; k++) hi[k] = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 7) begin
                bus.pulse_width = {15'd4, 15'd3, 15'd2, 15'd1};
                bus.data_update = 1'b1;
                exp_q.push_back({15'd4, 15'd3, 15'd2, 15'd1});
            end else if (i == 12) begin
                // Second update in the same frame replaces the pending one.
                bus.pulse_width = {15'd2, 15'd4, 15'd6, 15'd8};
                bus.data_update = 1'b1;
                void'(exp_q.pop_back());
                exp_q.push_back({15'd2, 15'd4, 15'd6, 15'd8});
            end else begin
                bus.data_update = 1'b0;
            end
            @(negedge clk);
            for (int k = 0; k < NUM_CH; k++) if (bus.pwm_out[k]) hi[k]++;
        end
        e = {15'd20, 15'd19, 15'd5, 15'd0};
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL mid_old_frame ch%0d got=%0d exp=%0d", k, hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
        checks++;
        if (bus.update_applied !== 1'b1) begin
            failures++; $display("FAIL mid_load_edge got=%b exp=1", bus.update_applied);
        end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL mid_new_frame ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
    endtask

    task automatic test_load_tick();
        exp_t e;
        for (int i = 1; i <= 20; i++) begin
            if (i == 20) begin
                bus.pulse_width = {15'd7, 15'd30, 15'd0, 15'd12};
                bus.data_update = 1'b1;
                exp_q.push_back({15'd7, 15'd20, 15'd0, 15'd12});
            end
            @(negedge clk);
        end
        bus.data_update = 1'b0;
        checks++;
        if (bus.update_applied !== 1'b1) begin
            failures++; $display("FAIL tick_load got=%b exp=1", bus.update_applied);
        end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL tick_high ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
        checks++;
        if (ua_seen != 0) begin
            failures++; $display("FAIL tick_no_extra_load got=%0d exp=0", ua_seen);
        end
    endtask

    task automatic test_period_lower();
        bit ok;
        int n;
        wait_fs(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL lower_wait_frame got=timeout exp=frame"); end
        repeat (14) @(negedge clk);
        checks++;
        if (bus.frame_start !== 1'b0) begin
            failures++; $display("FAIL lower_pre got=%b exp=0", bus.frame_start);
        end
        bus.pulse_period = 15'd10;
        @(negedge clk);
        checks++;
        if (bus.frame_start !== 1'b1) begin
            failures++; $display("FAIL lower_wrap got=%b exp=1", bus.frame_start);
        end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (bus.frame_start) break;
        end
        checks++;
        if (n != 10) begin
            failures++; $display("FAIL lower_new_len got=%0d exp=10", n);
        end
    endtask

    task automatic test_degenerate();
        int hi, fs;
        bus.pulse_period = 15'd1;
        send_update({15'd5, 15'd5, 15'd5, 15'd5});
        hi = 0; fs = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 30) bus.pulse_period = '0;
            @(negedge clk);
            if (bus.pwm_out != '0) hi++;
            if (bus.frame_start) fs++;
        end
        checks++;
        if (hi != 0) begin
            failures++; $display("FAIL degen_low got=%0d high cycles exp=0", hi);
        end
        checks++;
        if (fs != 0) begin
            failures++; $display("FAIL degen_frames got=%0d exp=0", fs);
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        bit   ok;
        bus.pulse_period = 15'd3000;
        bus.width_min    = 15'd900;
        bus.width_max    = 15'd2100;
        exp_q.push_back({15'd2100, 15'd1500, 15'd2100, 15'd900});
        send_update({15'd2100, 15'd1500, 15'd3000, 15'd500});
        wait_ua(4000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL clamp_load got=timeout exp=load"); end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL clamp_high ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
        // Inverted bounds: width_max wins.
        bus.pulse_period = 15'd20;
        bus.width_min    = 15'd25;
        bus.width_max    = 15'd18;
        exp_q.push_back({15'd18, 15'd18, 15'd18, 15'd18});
        send_update({15'd18, 15'd10, 15'd30, 15'd0});
        wait_ua(100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL inv_load got=timeout exp=load"); end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL inv_high ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
    endtask

    task automatic test_tick_gate();
        logic [NUM_CH-1:0] ref_pwm;
        int fs, chg, first, second;
        bus.pwm_tick = 1'b0;
        @(negedge clk);
        ref_pwm = bus.pwm_out;
        fs = 0; chg = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.frame_start) fs++;
            if (bus.pwm_out !== ref_pwm) chg++;
        end
        checks++;
        if (fs != 0 || chg != 0) begin
            failures++; $display("FAIL gate_frozen got=fs%0d/chg%0d exp=0/0", fs, chg);
        end
        first = -1; second = -1;
        for (int i = 0; i < 200; i++) begin
            bus.pwm_tick = (i % 2 == 0);
            @(negedge clk);
            if (bus.frame_start) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        bus.pwm_tick = 1'b1;
        checks++;
        if (first < 0 || second - first != 40) begin
            failures++; $display("FAIL gate_half_rate got=%0d exp=40", second - first);
        end
    endtask

`ifdef PWM_SERVO_FAILSAFE_EN
    task automatic test_failsafe();
        exp_t e;
        bit   ok;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.pulse_period   = 15'd20;
        bus.width_min      = '0;
        bus.width_max      = 15'd30;
        bus.failsafe_width = {15'd2, 15'd4, 15'd6, 15'd8};
        exp_q.push_back({15'd10, 15'd10, 15'd10, 15'd10});
        send_update({15'd10, 15'd10, 15'd10, 15'd10});
        exp_q.push_back({15'd2, 15'd4, 15'd6, 15'd8});
        wait_ua(100, ok);
        checks++;
        if (!ok || bus.failsafe_active !== 1'b0) begin
            failures++; $display("FAIL fs_first_load got=%b exp=0", bus.failsafe_active);
        end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL fs_normal ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
        checks++;
        if (bus.failsafe_active !== 1'b0) begin
            failures++; $display("FAIL fs_early1 got=%b exp=0", bus.failsafe_active);
        end
        wait_fs(100, ok);
        checks++;
        if (bus.failsafe_active !== 1'b0) begin
            failures++; $display("FAIL fs_early2 got=%b exp=0", bus.failsafe_active);
        end
        wait_fs(100, ok);
        checks++;
        if (!ok || bus.failsafe_active !== 1'b1) begin
            failures++; $display("FAIL fs_engage got=%b exp=1", bus.failsafe_active);
        end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL fs_widths ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
        exp_q.push_back({15'd9, 15'd9, 15'd9, 15'd9});
        send_update({15'd9, 15'd9, 15'd9, 15'd9});
        wait_ua(100, ok);
        checks++;
        if (!ok || bus.failsafe_active !== 1'b0) begin
            failures++; $display("FAIL fs_release got=%b exp=0", bus.failsafe_active);
        end
        measure_frame();
        e = exp_q.pop_front();
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            if (meas_hi[k] !== int'(e[k*WIDTH +: WIDTH])) begin
                failures++;
                $display("FAIL fs_restored ch%0d got=%0d exp=%0d", k, meas_hi[k],
                         int'(e[k*WIDTH +: WIDTH]));
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        int hi;
        wait_fs(100, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.pwm_out !== 4'hF) begin
            failures++; $display("FAIL rmid_pre_high got=%b exp=1111", bus.pwm_out);
        end
        checks++;
        if (bus.failsafe_active !== 1'b0) begin
            failures++; $display("FAIL rmid_failsafe got=%b exp=0", bus.failsafe_active);
        end
        bus.pwm_tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.pwm_out !== '0) begin
            failures++; $display("FAIL rmid_low got=%b exp=0", bus.pwm_out);
        end
        rst = 1'b0;
        bus.pwm_tick = 1'b1;
        hi = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.pwm_out != '0) hi++;
        end
        checks++;
        if (hi != 0) begin
            failures++; $display("FAIL rmid_stays_low got=%0d exp=0", hi);
        end
    endtask

    initial begin
        rst                = 1'b1;
        bus.pwm_tick       = 1'b0;
        bus.pulse_period   = 15'd20;
        bus.pulse_width    = '0;
        bus.width_min      = '0;
        bus.width_max      = 15'd30;
        bus.failsafe_width = '0;
        bus.data_update    = 1'b0;
        test_reset();
        test_basic();
        test_mid_frame();
        test_load_tick();
        test_period_lower();
        test_degenerate();
        test_clamp();
        test_tick_gate();
`ifdef PWM_SERVO_FAILSAFE_EN
        test_failsafe();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
